mem_arbiter: RTL and testbench

- Single-port, byte-wide RAM controller and arbiter for the 5-stage RISC-V core.
- Serves instruction fetches from IF and loads/stores from MEM over one 8-bit RAM bus, assembling and splitting 32-bit words little-endian.
- Produces the stall requests lock_from_IF and lock_from_MEM that drive the pipeline stall controller.

---
 rtl/mem_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : byte-wide single-port RAM controller, IF/MEM arbiter (MEM wins)
// Optional fetch buffer: MEM_ARBITER_FETCH_BUF_EN            Rev 1.0
// ============================================================================
module mem_arbiter #(
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              lock_from_IF,
  output logic              lock_from_MEM
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, len;
  logic [RAM_AW-1:0] base;
  logic [RAM_AW-1:0] next_addr;
  logic [31:0]       wbuf, asm_q, asm_nxt;
  logic [31:0]       fb_word;
  logic [1:0]        cap_idx, wr_idx;
  logic              acc_mem, acc_if, fb_hit, rd_last, wr_last, any_done;
  logic              unused_addr_bits;

  function automatic logic [2:0] size_len(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign lock_from_IF     = if_req & ~if_done;
  assign lock_from_MEM    = mem_req & ~mem_done;
  assign any_done         = if_done | mem_done;
  assign next_addr        = base + RAM_AW'(cnt + 3'd1);
  assign cap_idx          = 2'(cnt - 3'd1);
  assign wr_idx           = 2'(cnt + 3'd1);
  assign unused_addr_bits = ^{if_addr[31:RAM_AW], mem_addr[31:RAM_AW]};

`ifdef MEM_ARBITER_FETCH_BUF_EN
  logic        fb_valid;
  logic [31:0] fb_addr, fb_data, if_addr_q;

  assign fb_hit  = fb_valid && (fb_addr == if_addr);
  assign fb_word = fb_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_valid  <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      if_addr_q <= '0;
    end else begin
      if (acc_if)
        if_addr_q <= if_addr;
      if (acc_mem && mem_we) begin
        fb_valid <= 1'b0;
      end else if (rd_last && state == IF_RD) begin
        fb_valid <= 1'b1;
        fb_addr  <= if_addr_q;
        fb_data  <= asm_nxt;
      end
    end
  end
`else
  assign fb_hit  = 1'b0;
  assign fb_word = '0;
`endif

  // Byte k arrives one cycle after its address, i.e. while cnt == k+1.
  always_comb begin
    asm_nxt = asm_q;
    if ((state == IF_RD || state == MEM_RD) && cnt != 3'd0)
      asm_nxt[{cap_idx, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // The cycle carrying any done pulse is a turnaround cycle: nothing is accepted.
  always_comb begin
    state_nxt = state;
    acc_mem   = 1'b0;
    acc_if    = 1'b0;
    rd_last   = 1'b0;
    wr_last   = 1'b0;
    case (state)
      IDLE: begin
        if (!any_done) begin
          if (mem_req) begin
            acc_mem   = 1'b1;
            state_nxt = mem_we ? MEM_WR : MEM_RD;
          end else if (if_req && !fb_hit) begin
            acc_if    = 1'b1;
            state_nxt = IF_RD;
          end
        end
      end
      IF_RD, MEM_RD: begin
        if (cnt == len) begin
          rd_last   = 1'b1;
          state_nxt = IDLE;
        end
      end
      MEM_WR: begin
        if (cnt == len - 3'd1) begin
          wr_last   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      len       <= '0;
      base      <= '0;
      wbuf      <= '0;
      asm_q     <= '0;
      ram_addr  <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= '0;
      if_data   <= '0;
      if_done   <= 1'b0;
      mem_rdata <= '0;
      mem_done  <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      if (acc_mem) begin
        base     <= mem_addr[RAM_AW-1:0];
        ram_addr <= mem_addr[RAM_AW-1:0];
        len      <= size_len(mem_size);
        cnt      <= '0;
        asm_q    <= '0;
        wbuf     <= mem_wdata;
        if (mem_we) begin
          ram_wr   <= 1'b1;
          ram_dout <= mem_wdata[7:0];
        end
      end else if (acc_if) begin
        base     <= if_addr[RAM_AW-1:0];
        ram_addr <= if_addr[RAM_AW-1:0];
        len      <= 3'd4;
        cnt      <= '0;
        asm_q    <= '0;
      end else if (state == IDLE && !any_done && if_req && fb_hit) begin
        if_done <= 1'b1;
        if_data <= fb_word;
      end else begin
        case (state)
          IF_RD, MEM_RD: begin
            cnt   <= cnt + 3'd1;
            asm_q <= asm_nxt;
            if (cnt < len - 3'd1)
              ram_addr <= next_addr;
            if (rd_last) begin
              cnt <= '0;
              if (state == IF_RD) begin
                if_data <= asm_nxt;
                if_done <= 1'b1;
              end else begin
                mem_rdata <= asm_nxt;
                mem_done  <= 1'b1;
              end
            end
          end
          MEM_WR: begin
            if (wr_last) begin
              cnt      <= '0;
              ram_wr   <= 1'b0;
              mem_done <= 1'b1;
            end else begin
              cnt      <= cnt + 3'd1;
              ram_addr <= next_addr;
              ram_dout <= wbuf[{wr_idx, 3'b000} +: 8];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : scoreboard bench for mem_arbiter with a byte RAM model
// Rev 1.0
// ============================================================================
module tb_mem_arbiter;
  localparam int RAM_AW = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [31:0]       if_addr = '0;
  logic [31:0]       if_data;
  logic              if_done;
  logic              mem_req = 1'b0;
  logic              mem_we = 1'b0;
  logic [1:0]        mem_size = '0;
  logic [31:0]       mem_addr = '0;
  logic [31:0]       mem_wdata = '0;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din = '0;
  logic              lock_from_IF;
  logic              lock_from_MEM;

  always #5 clk = ~clk;

  mem_arbiter #(.RAM_AW(RAM_AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .lock_from_IF(lock_from_IF), .lock_from_MEM(lock_from_MEM)
  );

  bit [7:0] ram [0:(1<<RAM_AW)-1];

  always @(posedge clk) begin
    ram_din <= ram[ram_addr];
    if (ram_wr)
      ram[ram_addr] <= ram_dout;
  end

  typedef struct {
    logic [31:0] data;
    bit          chk;
    int          due;
  } exp_t;

  exp_t if_q[$];
  exp_t mem_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Every done pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (if_done) begin
      check("if_sb_nonempty", 32'(if_q.size() != 0), 32'd1);
      if (if_q.size() != 0) begin
        e = if_q.pop_front();
        check("if_data", if_data, e.data);
        check("if_cycle", 32'(cyc), 32'(e.due));
      end
    end
    if (mem_done) begin
      check("mem_sb_nonempty", 32'(mem_q.size() != 0), 32'd1);
      if (mem_q.size() != 0) begin
        e = mem_q.pop_front();
        if (e.chk)
          check("mem_rdata", mem_rdata, e.data);
        check("mem_cycle", 32'(cyc), 32'(e.due));
      end
    end
    if (if_done || mem_done)
      check("done_excl", 32'(if_done & mem_done), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int lat);
    exp_t e;
    if_addr = a;
    if_req  = 1'b1;
    e.data = d; e.chk = 1'b1; e.due = cyc + lat;
    if_q.push_back(e);
  endtask

  task automatic mem_op(input bit we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int lat);
    exp_t e;
    mem_we    = we;
    mem_size  = sz;
    mem_addr  = a;
    mem_wdata = wd;
    mem_req   = 1'b1;
    e.data = rd; e.chk = !we; e.due = cyc + lat;
    mem_q.push_back(e);
  endtask

  task automatic wait_done(input bit is_if, input int budget);
    bit    got;
    string tg;
    got = 1'b0;
    tg  = is_if ? "if" : "mem";
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (is_if ? if_done : mem_done) begin
        got = 1'b1;
        check({tg, "_lock_off"}, 32'(is_if ? lock_from_IF : lock_from_MEM), 32'd0);
        break;
      end
      check({tg, "_lock_on"}, 32'(is_if ? lock_from_IF : lock_from_MEM), 32'd1);
    end
    check({tg, "_done_seen"}, 32'(got), 32'd1);
    tick();
    if (is_if) if_req = 1'b0;
    else       mem_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tg);
    check({tg, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tg, "_ram_wr"}, 32'(ram_wr), 32'd0);
    check({tg, "_ram_dout"}, 32'(ram_dout), 32'd0);
    check({tg, "_if_data"}, if_data, 32'd0);
    check({tg, "_mem_rdata"}, mem_rdata, 32'd0);
    check({tg, "_if_done"}, 32'(if_done), 32'd0);
    check({tg, "_mem_done"}, 32'(mem_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int buf_lat;
    logic [31:0] buf_ra;
`ifdef MEM_ARBITER_FETCH_BUF_EN
    buf_lat = 1; buf_ra = 32'h13;
`else
    buf_lat = 6; buf_ra = 32'h10;
`endif
    ram[17'h10] <= 8'h11; ram[17'h11] <= 8'h22; ram[17'h12] <= 8'h33; ram[17'h13] <= 8'h44;
    ram[17'h21] <= 8'h77;
    ram[17'h30] <= 8'h5A; ram[17'h31] <= 8'hA5;
    ram[17'h40] <= 8'hDE; ram[17'h41] <= 8'hAD; ram[17'h42] <= 8'hBE; ram[17'h43] <= 8'hEF;
    ram[17'h50] <= 8'h01; ram[17'h51] <= 8'h23; ram[17'h52] <= 8'h45; ram[17'h53] <= 8'h67;

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    check("reset_lock_if", 32'(lock_from_IF), 32'd0);
    check("reset_lock_mem", 32'(lock_from_MEM), 32'd0);

    // Word fetch: address sequence and lock timing
    tick();
    fetch(32'h10, 32'h44332211, 6);
    @(negedge clk);
    check("t1_lock_T", 32'(lock_from_IF), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_ram_addr", 32'(ram_addr), 32'h10 + 32'(i));
      check("t1_ram_wr", 32'(ram_wr), 32'd0);
    end
    @(negedge clk);
    check("t1_lock_T5", 32'(lock_from_IF), 32'd1);
    wait_done(1'b1, 4);

    // Byte store
    tick();
    mem_op(1'b1, 2'b00, 32'h20, 32'hAABBCCDD, 32'h0, 2);
    @(negedge clk);
    check("t2_wr_T", 32'(ram_wr), 32'd0);
    @(negedge clk);
    check("t2_wr_T1", 32'(ram_wr), 32'd1);
    check("t2_addr_T1", 32'(ram_addr), 32'h20);
    check("t2_dout_T1", 32'(ram_dout), 32'hDD);
    wait_done(1'b0, 8);
    check("t2_ram20", 32'(ram[17'h20]), 32'hDD);
    check("t2_ram21", 32'(ram[17'h21]), 32'h77);

    // Word store and load across the address wrap, upper address bits ignored
    tick();
    mem_op(1'b1, 2'b10, 32'h8001FFFE, 32'h01020304, 32'h0, 5);
    wait_done(1'b0, 16);
    check("wrap_ram", {ram[17'h1], ram[17'h0], ram[17'h1FFFF], ram[17'h1FFFE]}, 32'h01020304);
    tick();
    mem_op(1'b0, 2'b10, 32'h0001FFFE, 32'h0, 32'h01020304, 6);
    wait_done(1'b0, 16);

    // Simultaneous requests: MEM first, fetch after turnaround
    tick();
    mem_op(1'b0, 2'b01, 32'h30, 32'h0, 32'h0000A55A, 4);
    fetch(32'h40, 32'hEFBEADDE, 11);
    fork
      wait_done(1'b0, 20);
      wait_done(1'b1, 20);
    join

    // Size 11 behaves as a word
    tick();
    mem_op(1'b0, 2'b11, 32'h40, 32'h0, 32'hEFBEADDE, 6);
    wait_done(1'b0, 16);

    // MEM request during an active fetch waits for it
    tick();
    fetch(32'h50, 32'h67452301, 6);
    fork
      wait_done(1'b1, 20);
      begin
        tick();
        tick();
        mem_op(1'b0, 2'b00, 32'h13, 32'h0, 32'h00000044, 8);
        wait_done(1'b0, 20);
      end
    join

    // Reset in the middle of a fetch; the held request restarts
    tick();
    if_addr = 32'h10;
    if_req  = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fetch(32'h10, 32'h44332211, 6);
    @(negedge clk);
    check_all_zero("t5");
    @(negedge clk);
    check("t5_restart_addr", 32'(ram_addr), 32'h10);
    wait_done(1'b1, 20);

    // Repeat fetch (buffer hit when enabled), then store invalidates
    tick();
    fetch(32'h10, 32'h44332211, buf_lat);
    fork
      wait_done(1'b1, 20);
      begin
        @(negedge clk);
        @(negedge clk);
        check("t6_ram_addr", 32'(ram_addr), buf_ra);
        check("t6_ram_wr", 32'(ram_wr), 32'd0);
      end
    join
    tick();
    mem_op(1'b1, 2'b00, 32'h60, 32'h99, 32'h0, 2);
    wait_done(1'b0, 8);
    tick();
    fetch(32'h10, 32'h44332211, 6);
    wait_done(1'b1, 20);

    repeat (3) tick();
    check("sb_empty", 32'(if_q.size() + mem_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
